// File: rtl/switch_cfg_pkg.sv
// Shared constants, side codes, error codes and FSM encoding for the switch
// box configuration loader.
package switch_cfg_pkg;

  localparam int unsigned NTB = 5;
  localparam int unsigned NLR = 4;
  localparam int unsigned WW  = 6;
  localparam int unsigned NW  = 2 * NTB + 2 * NLR;

  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [2:0] OFF    = 3'd0;
  localparam logic [2:0] TOP    = 3'd1;
  localparam logic [2:0] RIGHT  = 3'd2;
  localparam logic [2:0] BOTTOM = 3'd3;
  localparam logic [2:0] LEFT   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [1:0] {
    StHunt,
    StLoad,
    StCsum,
    StCheck
  } state_t;

endpackage

// File: rtl/cfg_word_check.sv
// Legality check of one routing word, given its side class and source wire
// index.
module cfg_word_check
  import switch_cfg_pkg::*;
(
  input  logic [2:0] side,
  input  logic [2:0] idx,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (side)
      OFF:         legal = 1'b1;
      TOP, BOTTOM: legal = (32'(idx) < NTB);
      RIGHT, LEFT: legal = (32'(idx) < NLR);
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial configuration loader: hunts for a sync byte, unpacks NW routing words
// into a shadow, verifies legality and checksum, then commits atomically.
module switch_cfg_loader
  import switch_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic             cfg_din,
  input  logic             cfg_abort,
  output logic [NW*WW-1:0] cfg_words,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [1:0]       err_code
);

  localparam logic [4:0] LastWord = 5'(NW - 1);
  localparam logic [2:0] LastWordBit = 3'(WW - 1);

  state_t           state_q;
  logic [7:0]       sync_q;
  logic [WW-1:0]    word_q;
  logic [2:0]       bit_cnt_q;
  logic [4:0]       word_cnt_q;
  logic [7:0]       acc_q;
  logic [7:0]       csum_q;
  logic             illegal_q;
  logic [NW*WW-1:0] shadow_q;

  logic [7:0]    sync_nxt;
  logic [WW-1:0] word_nxt;
  logic          word_legal;

  assign sync_nxt = {sync_q[6:0], cfg_din};
  assign word_nxt = {word_q[WW-2:0], cfg_din};

  cfg_word_check u_word_check (
    .side  (word_nxt[2:0]),
    .idx   (word_nxt[5:3]),
    .legal (word_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      sync_q     <= '0;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      acc_q      <= '0;
      csum_q     <= '0;
      illegal_q  <= 1'b0;
      shadow_q   <= '0;
      cfg_words  <= '0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      cfg_done <= 1'b0;
      // Abort outranks any bit or commit in flight; ignored while hunting.
      if (cfg_abort && (state_q != StHunt)) begin
        state_q  <= StHunt;
        cfg_busy <= 1'b0;
        cfg_err  <= 1'b1;
        err_code <= ERR_ABORT;
      end else begin
        unique case (state_q)
          StHunt: begin
            if (cfg_valid) begin
              if (sync_nxt == SYNC) begin
                state_q    <= StLoad;
                sync_q     <= '0;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                acc_q      <= '0;
                illegal_q  <= 1'b0;
                cfg_busy   <= 1'b1;
                cfg_err    <= 1'b0;
                err_code   <= ERR_NONE;
              end else begin
                sync_q <= sync_nxt;
              end
            end
          end
          StLoad: begin
            if (cfg_valid) begin
              word_q <= word_nxt;
              if (bit_cnt_q == LastWordBit) begin
                bit_cnt_q                      <= '0;
                shadow_q[word_cnt_q*WW +: WW] <= word_nxt;
                acc_q                          <= acc_q + 8'(word_nxt);
                illegal_q                      <= illegal_q | ~word_legal;
                if (word_cnt_q == LastWord) begin
                  state_q <= StCsum;
                end else begin
                  word_cnt_q <= word_cnt_q + 5'd1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          StCsum: begin
            if (cfg_valid) begin
              csum_q <= {csum_q[6:0], cfg_din};
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= '0;
                state_q   <= StCheck;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          StCheck: begin
            state_q  <= StHunt;
            cfg_busy <= 1'b0;
            if (illegal_q) begin
              cfg_err  <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else if (acc_q != csum_q) begin
              cfg_err  <= 1'b1;
              err_code <= ERR_CSUM;
            end else begin
              cfg_words <= shadow_q;
              cfg_done  <= 1'b1;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

endmodule
